// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: IDLE -> FETCH -> WAIT -> EXEC, then loops or halts on i_WrPC.
// Optional single-step mode (PAUSE state after every EXEC) is enabled by defining FETCH_STEP_EN.
module fetch_unit #(
  parameter int PC_WIDTH    = 11,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_WrPC,
  input  logic                   i_step,
  output logic [PC_WIDTH-1:0]    o_pm_addr,
  output logic                   o_pm_rd,
  input  logic [INSTR_WIDTH-1:0] i_pm_data,
  output logic [4:0]             o_opcode,
  output logic [INSTR_WIDTH-6:0] o_operand,
  output logic                   o_instr_valid,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic                   o_halted
);

`ifdef FETCH_STEP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_HALT, S_PAUSE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_HALT
  } state_t;

  // Single-step input has no role in the free-running build.
  logic w_unused_step;
  assign w_unused_step = i_step;
`endif

  state_t                 r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_ir;
  logic                   r_pm_rd;
  logic                   r_instr_valid;
  logic                   r_halted;

  // Strobes are registered alongside the state they belong to, so they are
  // asserted on the very cycle the FSM sits in FETCH / EXEC.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_ir          <= '0;
      r_pm_rd       <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so the defaults below are
      // simply overridden by the case arms and every reader sees pre-edge values.
      r_pm_rd       <= 1'b0;
      r_instr_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_FETCH;
            r_pm_rd <= 1'b1;
          end
        end
        S_FETCH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_ir          <= i_pm_data;
          r_state       <= S_EXEC;
          r_instr_valid <= 1'b1;
        end
        S_EXEC: begin
          if (i_WrPC) begin
            r_pc <= r_pc + PC_WIDTH'(1);
`ifdef FETCH_STEP_EN
            r_state <= S_PAUSE;
`else
            r_state <= S_FETCH;
            r_pm_rd <= 1'b1;
`endif
          end else begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
        end
`ifdef FETCH_STEP_EN
        S_PAUSE: begin
          if (i_step) begin
            r_state <= S_FETCH;
            r_pm_rd <= 1'b1;
          end
        end
`endif
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_pm_addr     = r_pc;
  assign o_pc          = r_pc;
  assign o_pm_rd       = r_pm_rd;
  assign o_instr_valid = r_instr_valid;
  assign o_halted      = r_halted;
  assign o_opcode      = r_ir[INSTR_WIDTH-1 -: 5];
  assign o_operand     = r_ir[INSTR_WIDTH-6:0];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 11: program counter and program memory address width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 16: instruction word width, opcode in [INSTR_WIDTH-1 -: 5], operand in [INSTR_WIDTH-6:0].
REQ-003 SHALL have port i_clock  input  1: single clock, all state updates on rising edge.
REQ-004 SHALL have port i_reset  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_start  input  1: level/pulse request to leave IDLE and begin fetching.
REQ-006 SHALL have port i_WrPC  input  1: decoder PC-write enable for the instruction currently in EXEC.
REQ-007 SHALL have port i_step  input  1: single-step advance pulse (used only when STEP_EN defined).
REQ-008 SHALL have port o_pm_addr  output  PC_WIDTH: program memory read address.
REQ-009 SHALL have port o_pm_rd  output  1: program memory read enable.
REQ-010 SHALL have port i_pm_data  input  INSTR_WIDTH: program memory read data, valid exactly one cycle after o_pm_rd high (synchronous read).
REQ-011 SHALL have port o_opcode  output  5: opcode field of instruction register, feeds decoder i_opcode.
REQ-012 SHALL have port o_operand  output  INSTR_WIDTH-5: operand field of instruction register.
REQ-013 SHALL have port o_instr_valid  output  1: high for exactly the EXEC cycle; downstream gates all register/RAM writes with it.
REQ-014 SHALL have port o_pc  output  PC_WIDTH: current program counter.
REQ-015 SHALL have port o_halted  output  1: high while in HALT.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, WAIT, EXEC, HALT (plus PAUSE when STEP_EN defined).
REQ-017 SHALL in IDLE hold o_pm_rd=0 and go to FETCH on the first rising edge with i_start=1.
REQ-018 SHALL in FETCH drive o_pm_rd=1, o_pm_addr=PC for one cycle, then go to WAIT.
REQ-019 SHALL in WAIT load IR <= i_pm_data, then go to EXEC; o_pm_rd=0.
REQ-020 SHALL in EXEC assert o_instr_valid=1 for one cycle, with o_opcode/o_operand stable from IR.
REQ-021 SHALL in EXEC with i_WrPC=1 update PC <= PC+1 modulo 2^PC_WIDTH and go to FETCH (or PAUSE per REQ-029).
REQ-022 SHALL in EXEC with i_WrPC=0 leave PC unchanged and go to HALT.
REQ-023 SHALL in HALT hold PC, IR, o_pm_rd=0, o_instr_valid=0, o_halted=1, ignore i_start and i_step; exit only via reset.
REQ-024 SHALL sample i_WrPC only in EXEC; i_WrPC in any other state has no effect.
REQ-025 SHALL give a fixed 3-cycle instruction period (FETCH, WAIT, EXEC) when free-running.
REQ-026 SHALL wrap PC from 2^PC_WIDTH-1 to 0 without halting.
REQ-027 SHALL drive o_opcode/o_operand from IR in every state; o_pm_addr equals PC in every state.

Reset
REQ-028 SHALL on i_reset=0, at any time including mid-fetch, immediately force state=IDLE, PC=0, IR=0, o_pm_rd=0, o_instr_valid=0, o_halted=0, o_opcode=0, o_operand=0; a read in flight is discarded.

Configuration
REQ-029 SHALL, with macro FETCH_STEP_EN defined, go EXEC->PAUSE on i_WrPC=1 (PC already incremented), hold in PAUSE with o_pm_rd=0 until a cycle with i_step=1, then go to FETCH; without FETCH_STEP_EN, PAUSE does not exist, EXEC->FETCH directly and i_step is ignored.

Verification
REQ-030 SHALL cover reset then i_start=1 with memory {0:0x1805,1:0x2003,2:0x0000} -> EXEC opcodes 0x03,0x04,0x00 on cycles 3,6,9 after start, o_halted=1 from cycle 10, PC=2.
REQ-031 SHALL cover i_WrPC held 1 from PC=0x7FF (PC_WIDTH=11) -> next o_pm_addr=0x000, o_halted=0.
REQ-032 SHALL cover i_reset=0 asserted during WAIT -> IR=0, PC=0, state IDLE same cycle, no EXEC pulse follows until i_start.
REQ-033 SHALL cover i_start and i_step toggled in HALT -> o_pm_rd stays 0, PC unchanged for 20 cycles.
REQ-034 SHALL cover FETCH_STEP_EN build: after first EXEC no o_pm_rd for 10 cycles; single i_step pulse -> exactly one FETCH/WAIT/EXEC with o_pm_addr=1.
REQ-035 SHALL cover i_WrPC=1 outside EXEC (IDLE, FETCH, WAIT) -> PC unchanged.
